emu_ctrl_seq: RTL and testbench
===============================

EMU_CTRL_SEQ -- requirements
Module: emu_ctrl_seq

Interface
REQ-001 Parameter TIME_W, default `TIME_WIDTH, width of emulation time and command data.
REQ-002 Parameter DT_W, default `DT_WIDTH, width of granted timestep input.
REQ-003 __emu_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 __emu_rst  in  1  reset, synchronous, active-high.
REQ-005 emu_dt  in  DT_W  timestep granted to the emulator this cycle.
REQ-006 cmd_valid  in  1  host command valid.
REQ-007 cmd_ready  out  1  sequencer can accept a command.
REQ-008 cmd_op  in  2  command opcode: 0 RUN, 1 STOP, 2 RUN_TO, 3 STEP.
REQ-009 cmd_data  in  TIME_W  RUN_TO absolute target time, or STEP size; ignored for RUN and STOP.
REQ-010 emu_ctrl_mode  out  4  mode to the time controller: 0 free-run, 1 stopped, 2 run-to-absolute, 3 bounded step.
REQ-011 emu_ctrl_data  out  TIME_W  operand for modes 2 and 3.
REQ-012 emu_time  out  TIME_W  accumulated emulation time.
REQ-013 emu_stalled  out  1  high when the FSM is in HOLD.
REQ-014 cmd_done  out  1  one-cycle pulse on natural completion of RUN_TO or STEP.

Function
REQ-015 The FSM SHALL have states HOLD, RUN, RUN_TO, STEP.
- Outputs per state: HOLD mode 1; RUN mode 0; RUN_TO mode 2; STEP mode 3.
- emu_ctrl_data holds the latched cmd_data in every state.
REQ-016 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both high.
- The new state and latched cmd_data take effect on the next cycle.
REQ-017 cmd_ready SHALL be high in HOLD, RUN and RUN_TO, and low in STEP.
REQ-018 Accepted commands SHALL transition as follows: RUN -> RUN, STOP -> HOLD, RUN_TO -> RUN_TO, STEP -> STEP.
- This applies from any state, and preempts the current operation without a cmd_done pulse.
REQ-019 emu_time SHALL update every cycle as emu_time + emu_dt.
- emu_dt is zero-extended to TIME_W.
- emu_time wraps modulo 2^TIME_W unless REQ-028 applies.
REQ-020 In RUN_TO, if emu_time >= latched target and no command is accepted that cycle, the next state SHALL be HOLD with cmd_done high for one cycle.
REQ-021 A RUN_TO whose target is <= emu_time at acceptance SHALL spend exactly one cycle in RUN_TO, then enter HOLD with cmd_done.
REQ-022 STEP SHALL last exactly one cycle, then enter HOLD with cmd_done high for one cycle.
REQ-023 Command acceptance coinciding with RUN_TO completion: the command SHALL win and cmd_done SHALL stay low.
REQ-024 cmd_done SHALL never be high in the same cycle as an accepted command's effect cycle, except when REQ-022 completes.
REQ-025 Output latency: emu_ctrl_mode and emu_ctrl_data are registered, 1 cycle after acceptance; emu_stalled is decoded from state.

Reset
REQ-026 While __emu_rst is high at a clock edge, the block SHALL set the following on the next cycle:
- state HOLD, emu_ctrl_mode 1, emu_ctrl_data 0, emu_time 0;
- cmd_done 0, emu_stalled 1, cmd_ready 1.
REQ-027 Reset mid-operation (any state) SHALL abandon the operation with no cmd_done pulse; cmd_valid is ignored during reset.

Configuration
REQ-028 Macro EMU_TIME_SAT_EN: when defined, emu_time SHALL saturate at all-ones instead of wrapping, and when undefined, emu_time SHALL wrap modulo 2^TIME_W.

Verification
REQ-029 Bench SHALL cover: reset, then RUN (op 0) with emu_dt=5 for 4 cycles -> emu_ctrl_mode=0, emu_time=20, emu_stalled=0.
REQ-030 Bench SHALL cover: from emu_time=20, RUN_TO target 50 with emu_dt driven as min(target-time, 8):
- emu_time goes 28,36,44,50;
- the cycle after reaching 50: HOLD, cmd_done=1 for one cycle, mode=1.
REQ-031 Bench SHALL cover: STEP size 7 with emu_dt=7 -> one cycle mode=3, emu_ctrl_data=7, cmd_ready=0 that cycle, then HOLD with cmd_done=1.
REQ-032 Bench SHALL cover: RUN_TO target 10 accepted with emu_time=30 -> one cycle mode=2, then HOLD with cmd_done=1, emu_time stays 30 with emu_dt=0.
REQ-033 Bench SHALL cover: STOP issued in the completion cycle of RUN_TO -> HOLD, cmd_done=0. Reset asserted mid-RUN -> emu_time=0, mode=1 next cycle.
REQ-034 Bench SHALL cover: emu_time = 2^TIME_W-3 with emu_dt=5 -> emu_time=2 without EMU_TIME_SAT_EN, and all-ones with it.

Source files
------------

// File: rtl/emu_ctrl_seq.sv
// Emulation control sequencer: it turns host commands into time-controller modes and accumulates emulation time.
// Optional feature: define EMU_TIME_SAT_EN to make emu_time saturate at all-ones instead of wrapping.
`ifndef TIME_WIDTH
`define TIME_WIDTH 32
`endif
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

module emu_ctrl_seq #(
    parameter int TIME_W = `TIME_WIDTH,
    parameter int DT_W   = `DT_WIDTH
) (
    input  logic              __emu_clk,
    input  logic              __emu_rst,
    input  logic [DT_W-1:0]   emu_dt,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [TIME_W-1:0] cmd_data,
    output logic [3:0]        emu_ctrl_mode,
    output logic [TIME_W-1:0] emu_ctrl_data,
    output logic [TIME_W-1:0] emu_time,
    output logic              emu_stalled,
    output logic              cmd_done
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_RUN_TO = 2'd2;
    localparam logic [1:0] S_STEP   = 2'd3;

    localparam logic [1:0] OP_RUN    = 2'd0;
    localparam logic [1:0] OP_STOP   = 2'd1;
    localparam logic [1:0] OP_RUN_TO = 2'd2;
    localparam logic [1:0] OP_STEP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [3:0]        mode_q, mode_d;
    logic [TIME_W-1:0] data_q, data_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              done_q, done_d;
    logic              accept;

    assign cmd_ready = (state_q != S_STEP);
    assign accept    = cmd_valid && cmd_ready;

`ifdef EMU_TIME_SAT_EN
    logic [TIME_W:0] time_sum;
    assign time_sum = {1'b0, time_q} + (TIME_W+1)'(emu_dt);
    assign time_d   = time_sum[TIME_W] ? '1 : time_sum[TIME_W-1:0];
`else
    assign time_d = time_q + TIME_W'(emu_dt);
`endif

    // An accepted command always takes priority over a completing RUN_TO, suppressing cmd_done.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (accept) begin
            case (cmd_op)
                OP_RUN:    state_d = S_RUN;
                OP_STOP:   state_d = S_HOLD;
                OP_RUN_TO: begin
                    state_d = S_RUN_TO;
                    data_d  = cmd_data;
                end
                default: begin
                    state_d = S_STEP;
                    data_d  = cmd_data;
                end
            endcase
        end else if (state_q == S_RUN_TO && time_q >= data_q) begin
            state_d = S_HOLD;
            done_d  = 1'b1;
        end else if (state_q == S_STEP) begin
            state_d = S_HOLD;
            done_d  = 1'b1;
        end
    end

    always_comb begin
        mode_d = 4'd1;
        case (state_d)
            S_RUN:    mode_d = 4'd0;
            S_HOLD:   mode_d = 4'd1;
            S_RUN_TO: mode_d = 4'd2;
            default:  mode_d = 4'd3;
        endcase
    end

    always_ff @(posedge __emu_clk) begin
        if (__emu_rst) begin
            state_q <= S_HOLD;
            mode_q  <= 4'd1;
            data_q  <= '0;
            time_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            time_q  <= time_d;
            done_q  <= done_d;
        end
    end

    assign emu_ctrl_mode = mode_q;
    assign emu_ctrl_data = data_q;
    assign emu_time      = time_q;
    assign emu_stalled   = (state_q == S_HOLD);
    assign cmd_done      = done_q;

endmodule

// File: tb/tb_emu_ctrl_seq.sv
// Bench for emu_ctrl_seq: directed scenarios plus random traffic checked against a command-level model.
module tb_emu_ctrl_seq;

    localparam int TW = 16;
    localparam int DW = 8;
    localparam longint TMOD = 64'd1 << TW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] dt;
    logic          valid;
    logic [1:0]    op;
    logic [TW-1:0] data;
    logic          cmd_ready;
    logic [3:0]    emu_ctrl_mode;
    logic [TW-1:0] emu_ctrl_data;
    logic [TW-1:0] emu_time;
    logic          emu_stalled;
    logic          cmd_done;

    int vectors     = 0;
    int miscompares = 0;

    // Model: current controller mode (1 = held), latched operand, time, pending done pulse
    int     m_mode;
    longint m_data;
    longint m_time;
    bit     m_done;

    emu_ctrl_seq #(.TIME_W(TW), .DT_W(DW)) dut (
        .__emu_clk     (clk),
        .__emu_rst     (rst),
        .emu_dt        (dt),
        .cmd_valid     (valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (op),
        .cmd_data      (data),
        .emu_ctrl_mode (emu_ctrl_mode),
        .emu_ctrl_data (emu_ctrl_data),
        .emu_time      (emu_time),
        .emu_stalled   (emu_stalled),
        .cmd_done      (cmd_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update();
        longint s;
        bit     completes;
        if (rst) begin
            m_mode = 1; m_data = 0; m_time = 0; m_done = 0;
        end else begin
            s = m_time + longint'(dt);
            if (s >= TMOD) begin
`ifdef EMU_TIME_SAT_EN
                s = TMOD - 1;
`else
                s = s - TMOD;
`endif
            end
            completes = (m_mode == 3) || (m_mode == 2 && m_time >= m_data);
            if (valid && m_mode != 3) begin
                m_mode = int'(op);
                if (op == 2'd2 || op == 2'd3) m_data = longint'(data);
                m_done = 0;
            end else if (completes) begin
                m_mode = 1;
                m_done = 1;
            end else begin
                m_done = 0;
            end
            m_time = s;
        end
    endtask

    task automatic check_all();
        chk("mode",    32'(emu_ctrl_mode), 32'(m_mode));
        chk("data",    32'(emu_ctrl_data), 32'(m_data));
        chk("time",    32'(emu_time),      32'(m_time));
        chk("stalled", 32'(emu_stalled),   32'(m_mode == 1));
        chk("done",    32'(cmd_done),      32'(m_done));
        chk("ready",   32'(cmd_ready),     32'(m_mode != 3));
    endtask

    task automatic cyc(input bit v, input int o, input longint d, input int t, input bit r);
        valid = v;
        op    = 2'(o);
        data  = TW'(d);
        dt    = DW'(t);
        rst   = r;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        int exp_t[4] = '{28, 36, 44, 50};
        valid = 0; op = 0; data = 0; dt = 0; rst = 1;

        // Reset
        cyc(0, 0, 0, 0, 1);
        chk("rst_mode", 32'(emu_ctrl_mode), 1);
        chk("rst_time", 32'(emu_time), 0);
        chk("rst_stall", 32'(emu_stalled), 1);
        chk("rst_ready", 32'(cmd_ready), 1);

        // RUN, dt=5 for 4 cycles
        cyc(1, 0, 0, 5, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 5, 0);
        chk("run_mode", 32'(emu_ctrl_mode), 0);
        chk("run_time", 32'(emu_time), 20);
        chk("run_stall", 32'(emu_stalled), 0);

        // RUN_TO 50 from 20
        cyc(1, 2, 50, 0, 0);
        chk("rt_mode", 32'(emu_ctrl_mode), 2);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, (50 - int'(m_time)) < 8 ? (50 - int'(m_time)) : 8, 0);
            chk("rt_time", 32'(emu_time), 32'(exp_t[i]));
        end
        cyc(0, 0, 0, 0, 0);
        chk("rt_done", 32'(cmd_done), 1);
        chk("rt_hold", 32'(emu_ctrl_mode), 1);
        cyc(0, 0, 0, 0, 0);
        chk("rt_done_pulse", 32'(cmd_done), 0);

        // STEP 7
        cyc(1, 3, 7, 7, 0);
        chk("st_mode", 32'(emu_ctrl_mode), 3);
        chk("st_data", 32'(emu_ctrl_data), 7);
        chk("st_ready", 32'(cmd_ready), 0);
        cyc(1, 0, 0, 7, 0);
        chk("st_done", 32'(cmd_done), 1);
        chk("st_hold", 32'(emu_ctrl_mode), 1);

        // RUN_TO 10 with time already 30
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 10, 0);
        cyc(0, 0, 0, 10, 0);
        cyc(0, 0, 0, 10, 0);
        cyc(1, 2, 10, 0, 0);
        chk("past_mode", 32'(emu_ctrl_mode), 2);
        cyc(0, 0, 0, 0, 0);
        chk("past_done", 32'(cmd_done), 1);
        chk("past_time", 32'(emu_time), 30);

        // STOP coinciding with RUN_TO completion
        cyc(1, 2, 40, 0, 0);
        cyc(0, 0, 0, 10, 0);
        cyc(1, 1, 0, 0, 0);
        chk("stop_done", 32'(cmd_done), 0);
        chk("stop_mode", 32'(emu_ctrl_mode), 1);

        // Reset mid-RUN with a command offered
        cyc(1, 0, 0, 3, 0);
        cyc(0, 0, 0, 3, 0);
        cyc(1, 3, 9, 3, 1);
        chk("mrst_time", 32'(emu_time), 0);
        chk("mrst_mode", 32'(emu_ctrl_mode), 1);
        chk("mrst_done", 32'(cmd_done), 0);

        // Time wrap / saturation boundary
        while (m_time != TMOD - 3)
            cyc(0, 0, 0, (TMOD - 3 - m_time) > 255 ? 255 : int'(TMOD - 3 - m_time), 0);
        cyc(0, 0, 0, 5, 0);
`ifdef EMU_TIME_SAT_EN
        chk("wrap_time", 32'(emu_time), 32'(TMOD - 1));
`else
        chk("wrap_time", 32'(emu_time), 2);
`endif

        // Random traffic
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            bit     r = ($urandom_range(0, 99) < 2);
            bit     v = ($urandom_range(0, 99) < 35);
            int     o = int'($urandom_range(0, 3));
            longint d = (o == 3) ? longint'($urandom_range(0, 20))
                                 : m_time + longint'($urandom_range(0, 120)) - 20;
            cyc(v, o, d, int'($urandom_range(0, 20)), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
